// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter
//   Round-robin arbiter and sequencer in front of the 8 x 32 register file.
//   It grants one requester per cycle. It turns READ / STORE / MOVE commands
//   into register-file control. A MOVE is split into a read cycle and a
//   separate write cycle (MOVE2), so a read bus never feeds the write input
//   combinationally.
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/op/waddr/raddr1/2/data  packed per-requester command fields
//   req_ready                       one-hot combinational grant
//   rsp_valid, rsp_err              one-hot completion pulse, illegal-op flag
//   rsp_rdata1/2                    captured read data
//   rf_raddr1/2, rf_waddr, rf_sto,
//   rf_wen, rf_dataIn               register-file control (held when idle)
//   rf_rdata1/2                     register-file read buses
module rf_port_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [AW*NREQ-1:0]   req_waddr,
    input  logic [AW*NREQ-1:0]   req_raddr1,
    input  logic [AW*NREQ-1:0]   req_raddr2,
    input  logic [DW*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic                 rsp_err,
    output logic [DW-1:0]        rsp_rdata1,
    output logic [DW-1:0]        rsp_rdata2,
    output logic [AW-1:0]        rf_raddr1,
    output logic [AW-1:0]        rf_raddr2,
    output logic [AW-1:0]        rf_waddr,
    output logic                 rf_sto,
    output logic                 rf_wen,
    output logic [DW-1:0]        rf_dataIn,
    input  logic [DW-1:0]        rf_rdata1,
    input  logic [DW-1:0]        rf_rdata2
);

    // Pointer width covers up to four requesters.
    localparam int PW = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_MOVE2 = 1'b1;

    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_MOVE  = 2'b11;

    logic [0:0]      state_r;
    logic [PW-1:0]   rr_r;
    logic [DW-1:0]   mv_hold_r;
    logic [AW-1:0]   mv_waddr_r;
    logic [PW-1:0]   mv_idx_r;
    logic [AW-1:0]   last_raddr1_r;
    logic [AW-1:0]   last_raddr2_r;
    logic [AW-1:0]   last_waddr_r;
    logic [DW-1:0]   last_data_r;
    logic [NREQ-1:0] rsp_valid_r;
    logic            rsp_err_r;
    logic [DW-1:0]   rsp_rdata1_r;
    logic [DW-1:0]   rsp_rdata2_r;

    logic            found_s;
    logic [PW-1:0]   win_idx_s;
    logic            accept_s;
    logic [NREQ-1:0] ready_s;
    logic [1:0]      sel_op_s;
    logic [AW-1:0]   sel_waddr_s;
    logic [AW-1:0]   sel_raddr1_s;
    logic [AW-1:0]   sel_raddr2_s;
    logic [DW-1:0]   sel_data_s;
    logic [AW-1:0]   rf_raddr1_s;
    logic [AW-1:0]   rf_raddr2_s;
    logic [AW-1:0]   rf_waddr_s;
    logic [DW-1:0]   rf_data_s;
    logic            rf_wen_s;
    logic            rf_sto_s;

    function automatic logic [NREQ-1:0] one_hot(input logic [PW-1:0] idx);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
        if (int'(idx) == NREQ - 1) begin
            return 2'd0;
        end else begin
            return idx + 2'd1;
        end
    endfunction

    // Round-robin search: first valid requester at or after rr wins.
    always_comb begin
        found_s   = 1'b0;
        win_idx_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && req_valid[(int'(rr_r) + k) % NREQ]) begin
                found_s   = 1'b1;
                win_idx_s = PW'((int'(rr_r) + k) % NREQ);
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Grant qualification and winner field selection.
    always_comb begin
        accept_s     = (state_r == ST_IDLE) && !rst && found_s;
        sel_op_s     = req_op[int'(win_idx_s)*2 +: 2];
        sel_waddr_s  = req_waddr[int'(win_idx_s)*AW +: AW];
        sel_raddr1_s = req_raddr1[int'(win_idx_s)*AW +: AW];
        sel_raddr2_s = req_raddr2[int'(win_idx_s)*AW +: AW];
        sel_data_s   = req_data[int'(win_idx_s)*DW +: DW];
        if (accept_s) begin
            ready_s = one_hot(win_idx_s);
        end else begin
            ready_s = '0;
        end
    end

    // Register-file control; addresses and data hold their last value when idle.
    always_comb begin
        rf_raddr1_s = last_raddr1_r;
        rf_raddr2_s = last_raddr2_r;
        rf_waddr_s  = last_waddr_r;
        rf_data_s   = last_data_r;
        rf_wen_s    = 1'b0;
        rf_sto_s    = 1'b0;
        if (rst) begin
            rf_wen_s = 1'b0;
        end else if (state_r == ST_MOVE2) begin
            rf_wen_s   = 1'b1;
            rf_sto_s   = 1'b1;
            rf_waddr_s = mv_waddr_r;
            rf_data_s  = mv_hold_r;
        end else if (accept_s) begin
            case (sel_op_s)
                OP_STORE: begin
                    rf_wen_s   = 1'b1;
                    rf_sto_s   = 1'b1;
                    rf_waddr_s = sel_waddr_s;
                    rf_data_s  = sel_data_s;
                end
                OP_MOVE: begin
                    rf_raddr1_s = sel_raddr1_s;
                end
                // READ and the illegal op both present read addresses only
                default: begin
                    rf_raddr1_s = sel_raddr1_s;
                    rf_raddr2_s = sel_raddr2_s;
                end
            endcase
        end else begin
            rf_wen_s = 1'b0;
        end
    end

    // Sequencer state, round-robin pointer, MOVE holding and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            rr_r          <= '0;
            mv_hold_r     <= '0;
            mv_waddr_r    <= '0;
            mv_idx_r      <= '0;
            last_raddr1_r <= '0;
            last_raddr2_r <= '0;
            last_waddr_r  <= '0;
            last_data_r   <= '0;
            rsp_valid_r   <= '0;
            rsp_err_r     <= 1'b0;
            rsp_rdata1_r  <= '0;
            rsp_rdata2_r  <= '0;
        end else begin
            last_raddr1_r <= rf_raddr1_s;
            last_raddr2_r <= rf_raddr2_s;
            last_waddr_r  <= rf_waddr_s;
            last_data_r   <= rf_data_s;
            rsp_valid_r   <= '0;
            rsp_err_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        rr_r <= next_ptr(win_idx_s);
                        case (sel_op_s)
                            OP_READ: begin
                                rsp_valid_r  <= one_hot(win_idx_s);
                                rsp_rdata1_r <= rf_rdata1;
                                rsp_rdata2_r <= rf_rdata2;
                            end
                            OP_STORE: begin
                                rsp_valid_r <= one_hot(win_idx_s);
                            end
                            OP_MOVE: begin
                                mv_hold_r  <= rf_rdata1;
                                mv_waddr_r <= sel_waddr_s;
                                mv_idx_r   <= win_idx_s;
                                state_r    <= ST_MOVE2;
                            end
                            default: begin
                                rsp_valid_r  <= one_hot(win_idx_s);
                                rsp_err_r    <= 1'b1;
                                rsp_rdata1_r <= rf_rdata1;
                                rsp_rdata2_r <= rf_rdata2;
                            end
                        endcase
                    end else begin
                        rr_r <= rr_r;
                    end
                end
                ST_MOVE2: begin
                    rsp_valid_r  <= one_hot(mv_idx_r);
                    rsp_rdata1_r <= mv_hold_r;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = ready_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_err    = rsp_err_r;
    assign rsp_rdata1 = rsp_rdata1_r;
    assign rsp_rdata2 = rsp_rdata2_r;
    assign rf_raddr1  = rf_raddr1_s;
    assign rf_raddr2  = rf_raddr2_s;
    assign rf_waddr   = rf_waddr_s;
    assign rf_dataIn  = rf_data_s;
    assign rf_wen     = rf_wen_s;
    assign rf_sto     = rf_sto_s;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb_rf_port_arbiter
//   Directed bench for rf_port_arbiter with a behavioural 8 x 32 register
//   file. Expected responses are queued at grant time. A monitor pops and
//   compares them whenever rsp_valid is seen.
module tb_rf_port_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 3;

    localparam logic [1:0] OP_ILL   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_MOVE  = 2'b11;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [2*NREQ-1:0]   req_op;
    logic [AW*NREQ-1:0]  req_waddr;
    logic [AW*NREQ-1:0]  req_raddr1;
    logic [AW*NREQ-1:0]  req_raddr2;
    logic [DW*NREQ-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic                rsp_err;
    logic [DW-1:0]       rsp_rdata1;
    logic [DW-1:0]       rsp_rdata2;
    logic [AW-1:0]       rf_raddr1;
    logic [AW-1:0]       rf_raddr2;
    logic [AW-1:0]       rf_waddr;
    logic                rf_sto;
    logic                rf_wen;
    logic [DW-1:0]       rf_dataIn;
    logic [DW-1:0]       rf_rdata1;
    logic [DW-1:0]       rf_rdata2;

    typedef struct {
        logic [NREQ-1:0] vld;
        logic            err;
        logic [31:0]     d1;
        logic [31:0]     d2;
        logic            c1;
        logic            c2;
        int              due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] rf_mem [8];

    rf_port_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_waddr  (req_waddr),
        .req_raddr1 (req_raddr1),
        .req_raddr2 (req_raddr2),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata1 (rsp_rdata1),
        .rsp_rdata2 (rsp_rdata2),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_waddr   (rf_waddr),
        .rf_sto     (rf_sto),
        .rf_wen     (rf_wen),
        .rf_dataIn  (rf_dataIn),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to check response latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural register file: writes only on the strobe.
    always @(posedge clk) begin
        if (rf_wen && rf_sto) rf_mem[rf_waddr] <= rf_dataIn;
    end
    assign rf_rdata1 = rf_mem[rf_raddr1];
    assign rf_rdata2 = rf_mem[rf_raddr2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (rsp_valid !== '0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got valid=%b expected none", rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'(mon_e.vld));
                check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                check("rsp_latency", 32'(cyc), 32'(mon_e.due));
                if (mon_e.c1) check("rsp_rdata1", rsp_rdata1, mon_e.d1);
                if (mon_e.c2) check("rsp_rdata2", rsp_rdata2, mon_e.d2);
            end
        end
    end

    task automatic set_req(input int i, input logic [1:0] op, input logic [2:0] wa,
                           input logic [2:0] ra1, input logic [2:0] ra2, input logic [31:0] d);
        req_op[i*2 +: 2]      = op;
        req_waddr[i*AW +: AW]  = wa;
        req_raddr1[i*AW +: AW] = ra1;
        req_raddr2[i*AW +: AW] = ra2;
        req_data[i*DW +: DW]   = d;
        req_valid[i]           = 1'b1;
    endtask

    task automatic push_exp(input logic [NREQ-1:0] vld, input logic err, input logic [31:0] d1,
                            input logic [31:0] d2, input logic c1, input logic c2, input int lat);
        exp_t e;
        e.vld = vld; e.err = err; e.d1 = d1; e.d2 = d2; e.c1 = c1; e.c2 = c2; e.due = cyc + lat;
        sb.push_back(e);
    endtask

    // One request from requester i, granted in the following cycle.
    task automatic issue(input int i, input logic [1:0] op, input logic [2:0] wa, input logic [2:0] ra1,
                         input logic [2:0] ra2, input logic [31:0] d, input logic push,
                         input logic [31:0] e1, input logic [31:0] e2, input logic c1, input logic c2);
        logic [NREQ-1:0] oh;
        oh = 3'b001 << i;
        set_req(i, op, wa, ra1, ra2, d);
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(oh));
        if (op == OP_STORE) begin
            check("store_wen", 32'(rf_wen), 32'd1);
            check("store_sto", 32'(rf_sto), 32'd1);
            check("store_waddr", 32'(rf_waddr), 32'(wa));
            check("store_data", rf_dataIn, d);
        end else begin
            check("nowrite_wen", 32'(rf_wen), 32'd0);
            check("rd_raddr1", 32'(rf_raddr1), 32'(ra1));
            if (op != OP_MOVE) check("rd_raddr2", 32'(rf_raddr2), 32'(ra2));
        end
        if (push) push_exp(oh, (op == OP_ILL), e1, e2, c1, c2, (op == OP_MOVE) ? 2 : 1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    logic [31:0] rr_e1 [3];
    logic [31:0] rr_e2 [3];

    initial begin
        for (int r = 0; r < 8; r++) rf_mem[r] = 32'd0;
        rst        = 1'b1;
        req_valid  = '0;
        req_op     = '0;
        req_waddr  = '0;
        req_raddr1 = '0;
        req_raddr2 = '0;
        req_data   = '0;

        // Reset: grants suppressed even with every requester valid.
        @(posedge clk);
        #1;
        req_valid = 3'b111;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rdata1", rsp_rdata1, 32'd0);
        check("rst_rdata2", rsp_rdata2, 32'd0);
        check("rst_wen", 32'(rf_wen), 32'd0);
        check("rst_sto", 32'(rf_sto), 32'd0);
        check("rst_raddr1", 32'(rf_raddr1), 32'd0);
        check("rst_waddr", 32'(rf_waddr), 32'd0);
        check("rst_dataIn", rf_dataIn, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;

        // STORE r5 then READ it back from two other requesters.
        issue(0, OP_STORE, 3'd5, 3'd0, 3'd0, 32'hDEAD_BEEF, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        issue(1, OP_READ, 3'd0, 3'd5, 3'd6, 32'd0, 1'b1, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1);
        issue(2, OP_READ, 3'd0, 3'd5, 3'd5, 32'd0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1);

        // All three requesters valid for six cycles: grants rotate 0,1,2,0,1,2.
        rr_e1[0] = 32'hDEAD_BEEF; rr_e2[0] = 32'd0;
        rr_e1[1] = 32'd0;         rr_e2[1] = 32'hDEAD_BEEF;
        rr_e1[2] = 32'hDEAD_BEEF; rr_e2[2] = 32'hDEAD_BEEF;
        set_req(0, OP_READ, 3'd0, 3'd5, 3'd0, 32'd0);
        set_req(1, OP_READ, 3'd0, 3'd0, 3'd5, 32'd0);
        set_req(2, OP_READ, 3'd0, 3'd5, 3'd5, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rr_grant", 32'(req_ready), 32'(3'b001 << (k % 3)));
            push_exp(3'b001 << (k % 3), 1'b0, rr_e1[k % 3], rr_e2[k % 3], 1'b1, 1'b1, 1);
            @(posedge clk);
            #1;
        end
        req_valid = '0;

        // Move pointer to 1, then MOVE r5->r2 from req 1 with req 0 also pending.
        issue(0, OP_READ, 3'd0, 3'd2, 3'd5, 32'd0, 1'b1, 32'd0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        set_req(0, OP_READ, 3'd0, 3'd2, 3'd0, 32'd0);
        set_req(1, OP_MOVE, 3'd2, 3'd5, 3'd0, 32'd0);
        @(negedge clk);
        check("move_grant", 32'(req_ready), 32'b010);
        check("move_raddr1", 32'(rf_raddr1), 32'd5);
        check("move_nowen", 32'(rf_wen), 32'd0);
        push_exp(3'b010, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0, 2);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("move2_ready", 32'(req_ready), 32'd0);
        check("move2_wen", 32'(rf_wen), 32'd1);
        check("move2_sto", 32'(rf_sto), 32'd1);
        check("move2_waddr", 32'(rf_waddr), 32'd2);
        check("move2_data", rf_dataIn, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("after_move_grant", 32'(req_ready), 32'b001);
        push_exp(3'b001, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1, 1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;

        // STORE r3 then READ r3 from another requester in the next cycle.
        issue(2, OP_STORE, 3'd3, 3'd0, 3'd0, 32'h0000_1234, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        issue(0, OP_READ, 3'd0, 3'd3, 3'd2, 32'd0, 1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 1'b1, 1'b1);

        // Illegal op from req 2.
        issue(2, OP_ILL, 3'd0, 3'd3, 3'd5, 32'd0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);

        // Reset during MOVE2 of MOVE r1->r4 suppresses the write and response.
        issue(0, OP_STORE, 3'd1, 3'd0, 3'd0, 32'hCAFE_0001, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        issue(1, OP_MOVE, 3'd4, 3'd1, 3'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        set_req(2, OP_READ, 3'd0, 3'd4, 3'd4, 32'd0);
        @(negedge clk);
        check("rstmv_wen", 32'(rf_wen), 32'd0);
        check("rstmv_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("rstmv_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstmv_rdata1", rsp_rdata1, 32'd0);
        check("rstmv_waddr", 32'(rf_waddr), 32'd0);
        check("rstmv_dataIn", rf_dataIn, 32'd0);
        check("rstmv_raddr1", 32'(rf_raddr1), 32'd0);
        @(posedge clk);
        #1;
        set_req(1, OP_READ, 3'd0, 3'd4, 3'd4, 32'd0);
        set_req(2, OP_READ, 3'd0, 3'd4, 3'd4, 32'd0);
        issue(0, OP_READ, 3'd0, 3'd4, 3'd1, 32'd0, 1'b1, 32'd0, 32'hCAFE_0001, 1'b1, 1'b1);
        req_valid = '0;

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
